mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/rr_pick2.sv | 17 +
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding,
// owner codes and a helper that sizes the wait counter.
`ifndef MEM_ARBITER_PKG_SV
`define MEM_ARBITER_PKG_SV
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_CPU  = 2'd1;
  localparam logic [1:0] OWNER_DMA  = 2'd2;

  // Wait counter is never narrower than 4 bits, wider if TIMEOUT needs it.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout);
    return (w < 4) ? 4 : w;
  endfunction

endpackage
`endif

// File: rtl/rr_pick2.sv
// Two-way round-robin pick. A lone requester always wins; on a tie the
// requester that was not served last wins.
module rr_pick2 (
  input  logic cpu_req,
  input  logic dma_req,
  input  logic last_dma,
  output logic pick_cpu,
  output logic pick_dma
);

  // CPU wins alone or on a tie when DMA was served last.
  always_comb begin
    pick_cpu = cpu_req && (!dma_req || last_dma);
    pick_dma = dma_req && !pick_cpu;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between a CPU and a DMA requester.
//
// Handshake: a requester raises req with addr/wdata/we stable; the inputs
// are sampled only in IDLE, so once gnt is high the requester may drop or
// change them freely. Completion is a single-cycle ack (with err for a
// timeout). On the memory side mem_en stays high with stable addr/wdata/we
// until the memory raises mem_ready for one cycle, or the wait counter
// expires after TIMEOUT cycles.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_we,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  input  logic        dma_we,
  output logic        cpu_gnt,
  output logic        dma_gnt,
  output logic        cpu_ack,
  output logic        dma_ack,
  output logic [15:0] rdata,
  output logic        err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output arb_state_t  state_dbg
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  arb_state_t    state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          pick_cpu, pick_dma;

  rr_pick2 u_pick (
    .cpu_req  (cpu_req),
    .dma_req  (dma_req),
    .last_dma (last_q == OWNER_DMA),
    .pick_cpu (pick_cpu),
    .pick_dma (pick_dma)
  );

  // Next-state and next-register values for the arbiter FSM.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_cpu) begin
          owner_d = OWNER_CPU;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          we_d    = cpu_we;
          wait_d  = '0;
          state_d = ST_ACCESS;
        end else if (pick_dma) begin
          owner_d = OWNER_DMA;
          addr_d  = dma_addr;
          wdata_d = dma_wdata;
          we_d    = dma_we;
          wait_d  = '0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // A ready in the final wait cycle still completes normally.
        if (mem_ready) begin
          if (!we_q) rdata_d = mem_rdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_RESP: begin
        last_d  = owner_q;
        owner_d = OWNER_NONE;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        owner_d = OWNER_NONE;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset leaves DMA as last served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_NONE;
      last_q  <= OWNER_DMA;
      wait_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode from registers only, so reset clears them immediately.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    cpu_gnt   = busy && (owner_q == OWNER_CPU);
    dma_gnt   = busy && (owner_q == OWNER_DMA);
    cpu_ack   = (state_q == ST_RESP) && (owner_q == OWNER_CPU);
    dma_ack   = (state_q == ST_RESP) && (owner_q == OWNER_DMA);
    mem_en    = (state_q == ST_ACCESS);
    mem_we    = mem_en && we_q;
    mem_addr  = mem_en ? addr_q : 16'h0000;
    mem_wdata = mem_en ? wdata_q : 16'h0000;
    rdata     = rdata_q;
    err       = err_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, CPU read, round-robin contention,
// DMA write with wait states, timeout, reset mid-access, dropped request.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_gnt, dma_gnt, cpu_ack, dma_ack, err;
  logic        mem_en, mem_we, mem_ready, busy;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
  arb_state_t  state_dbg;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Expected ack order under contention: 1 = CPU, 2 = DMA.
  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .dma_req   (dma_req),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_we    (dma_we),
    .cpu_gnt   (cpu_gnt),
    .dma_gnt   (dma_gnt),
    .cpu_ack   (cpu_ack),
    .dma_ack   (dma_ack),
    .rdata     (rdata),
    .err       (err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_req = 1'b1; dma_req = 1'b1;
    cpu_addr = 16'h1111; cpu_wdata = 16'h2222; cpu_we = 1'b1;
    dma_addr = 16'h3333; dma_wdata = 16'h4444; dma_we = 1'b1;
    mem_ready = 1'b1; mem_rdata = 16'hFFFF;
    #3;
    chk_cnt++;
    if ({cpu_gnt, dma_gnt, cpu_ack, dma_ack, err, mem_en, mem_we, busy} !== 8'h00)
      $display("FAIL reset_ctl: got %b want 00000000",
               {cpu_gnt, dma_gnt, cpu_ack, dma_ack, err, mem_en, mem_we, busy});
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({rdata, mem_addr, mem_wdata} !== 48'h0 || state_dbg !== ST_IDLE || busy !== 1'b0)
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h state=%0d busy=%b want 0",
               rdata, mem_addr, mem_wdata, state_dbg, busy);
    else pass_cnt++;
    cpu_req = 1'b0; dma_req = 1'b0; mem_ready = 1'b0;
    cpu_we = 1'b0; dma_we = 1'b0;
    reset = 1'b0;
    step();
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL idle_no_req: busy=%b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_addr = 16'h0040; cpu_we = 1'b0;
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    step();
    cpu_req = 1'b0;
    chk_cnt++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h0040 || mem_we !== 1'b0 ||
        cpu_gnt !== 1'b1 || dma_gnt !== 1'b0 || cpu_ack !== 1'b0)
      $display("FAIL rd_access: en=%b addr=%h we=%b gnt=%b/%b ack=%b want 1 0040 0 1/0 0",
               mem_en, mem_addr, mem_we, cpu_gnt, dma_gnt, cpu_ack);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (cpu_ack !== 1'b1 || rdata !== 16'hBEEF || err !== 1'b0 || mem_en !== 1'b0 ||
        mem_addr !== 16'h0000 || cpu_gnt !== 1'b1)
      $display("FAIL rd_resp: ack=%b rdata=%h err=%b en=%b addr=%h gnt=%b want 1 beef 0 0 0000 1",
               cpu_ack, rdata, err, mem_en, mem_addr, cpu_gnt);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (cpu_ack !== 1'b0 || busy !== 1'b0 || cpu_gnt !== 1'b0)
      $display("FAIL rd_idle: ack=%b busy=%b gnt=%b want 0 0 0", cpu_ack, busy, cpu_gnt);
    else pass_cnt++;
    mem_ready = 1'b0;
  endtask

  task automatic test_contention();
    int bad = 0;
    apply_reset();
    exp_q = '{2'd1, 2'd2, 2'd1};
    got_q = {};
    cpu_req = 1'b1; cpu_addr = 16'h0100; cpu_we = 1'b0;
    dma_req = 1'b1; dma_addr = 16'h0200; dma_we = 1'b0;
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    for (int i = 0; i < 8; i++) begin
      step();
      if ((cpu_gnt && dma_gnt) || (state_dbg == ST_IDLE && (cpu_gnt || dma_gnt))) bad++;
      if (cpu_ack) got_q.push_back(2'd1);
      if (dma_ack) got_q.push_back(2'd2);
    end
    cpu_req = 1'b0; dma_req = 1'b0; mem_ready = 1'b0;
    step();
    chk_cnt++;
    if (bad != 0) $display("FAIL gnt_overlap: got %0d bad cycles want 0", bad);
    else pass_cnt++;
    chk_cnt++;
    if (got_q.size() != exp_q.size())
      $display("FAIL rr_count: got %0d acks want %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_cnt++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL rr_order[%0d]: got %0d want %0d", i,
                 (i < got_q.size()) ? got_q[i] : 2'd0, exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_dma_write();
    int bad = 0;
    int acks = 0;
    dma_req = 1'b1; dma_addr = 16'h1234; dma_wdata = 16'h00FF; dma_we = 1'b1;
    mem_ready = 1'b0; mem_rdata = 16'h5555;
    for (int c = 0; c < 4; c++) begin
      step();
      dma_req = 1'b0;
      if (c == 3) mem_ready = 1'b1;
      if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h1234 ||
          mem_wdata !== 16'h00FF || dma_gnt !== 1'b1 || dma_ack !== 1'b0) bad++;
    end
    chk_cnt++;
    if (bad != 0) $display("FAIL wr_stable: got %0d bad cycles want 0", bad);
    else pass_cnt++;
    for (int c = 0; c < 4; c++) begin
      step();
      mem_ready = 1'b0;
      if (dma_ack) begin
        acks++;
        chk_cnt++;
        if (rdata !== 16'hBEEF || err !== 1'b0)
          $display("FAIL wr_resp: rdata=%h err=%b want beef 0", rdata, err);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (acks != 1) $display("FAIL wr_ack_count: got %0d want 1", acks);
    else pass_cnt++;
    dma_we = 1'b0;
  endtask

  task automatic test_timeout();
    int en_cnt = 0;
    int n = 0;
    cpu_req = 1'b1; cpu_addr = 16'h0ABC; cpu_we = 1'b0;
    mem_ready = 1'b0; mem_rdata = 16'h7777;
    step();
    cpu_req = 1'b0;
    while (!cpu_ack && n < 40) begin
      if (mem_en) en_cnt++;
      step();
      n++;
    end
    chk_cnt++;
    if (en_cnt != 15) $display("FAIL to_en_cycles: got %0d want 15", en_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (cpu_ack !== 1'b1 || err !== 1'b1 || rdata !== 16'hBEEF)
      $display("FAIL to_resp: ack=%b err=%b rdata=%h want 1 1 beef", cpu_ack, err, rdata);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (busy !== 1'b0 || err !== 1'b0 || cpu_ack !== 1'b0)
      $display("FAIL to_idle: busy=%b err=%b ack=%b want 0 0 0", busy, err, cpu_ack);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    cpu_req = 1'b1; cpu_addr = 16'h0404; cpu_we = 1'b0;
    mem_ready = 1'b0;
    step();
    chk_cnt++;
    if (mem_en !== 1'b1) $display("FAIL rst_mid_pre: mem_en=%b want 1", mem_en);
    else pass_cnt++;
    cpu_req = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_cnt++;
    if (mem_en !== 1'b0 || cpu_gnt !== 1'b0 || busy !== 1'b0 || cpu_ack !== 1'b0)
      $display("FAIL rst_mid_async: en=%b gnt=%b busy=%b ack=%b want 0 0 0 0",
               mem_en, cpu_gnt, busy, cpu_ack);
    else pass_cnt++;
    step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (cpu_ack || dma_ack) acks++;
      step();
    end
    chk_cnt++;
    if (acks != 0 || busy !== 1'b0) $display("FAIL rst_mid_noack: acks=%0d busy=%b want 0 0", acks, busy);
    else pass_cnt++;
    cpu_req = 1'b1; cpu_addr = 16'h0808;
    mem_ready = 1'b1; mem_rdata = 16'hCAFE;
    step();
    cpu_req = 1'b0;
    step();
    chk_cnt++;
    if (cpu_ack !== 1'b1 || rdata !== 16'hCAFE || err !== 1'b0)
      $display("FAIL rst_mid_after: ack=%b rdata=%h err=%b want 1 cafe 0", cpu_ack, rdata, err);
    else pass_cnt++;
    mem_ready = 1'b0;
    step();
  endtask

  task automatic test_req_drop();
    int acks = 0;
    cpu_req = 1'b1; cpu_addr = 16'h0C0C; cpu_we = 1'b0;
    mem_ready = 1'b0; mem_rdata = 16'h1357;
    step();
    cpu_req = 1'b0;
    step();
    chk_cnt++;
    if (mem_en !== 1'b1 || cpu_gnt !== 1'b1)
      $display("FAIL drop_hold: en=%b gnt=%b want 1 1", mem_en, cpu_gnt);
    else pass_cnt++;
    mem_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      mem_ready = 1'b0;
      if (cpu_ack) begin
        acks++;
        chk_cnt++;
        if (rdata !== 16'h1357) $display("FAIL drop_rdata: got %h want 1357", rdata);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (acks != 1) $display("FAIL drop_ack_count: got %0d want 1", acks);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_contention();
    test_dma_write();
    test_timeout();
    test_reset_mid();
    test_req_drop();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
